// File: rtl/xbar_pkg.sv
// -----------------------------------------------------------------------------
// xbar_pkg
// Shared types and constants for the W-channel scheduler.
//   MID_WIDTH   : master-index width for the default 4-master configuration
//   aw_state_t  : AW arbitration FSM states
//   mid_width_f : master-index width for any master count (min 1 bit)
// -----------------------------------------------------------------------------
package xbar_pkg;

    localparam int NUM_MASTERS_DEFAULT = 4;
    localparam int MID_WIDTH           = $clog2(NUM_MASTERS_DEFAULT);

    typedef enum logic [0:0] {
        AW_IDLE = 1'b0,
        AW_HOLD = 1'b1
    } aw_state_t;

    // Index width for a given master count; a single master still needs one bit.
    function automatic int mid_width_f(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/w_order_fifo.sv
// -----------------------------------------------------------------------------
// w_order_fifo
// Order queue of granted master indices. Extra-bit read/write pointers let
// every one of the DEPTH entries hold data (full and empty are told apart by
// the pointer MSB).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push/push_data: enqueue one index (ignored when full)
//   pop           : dequeue the head (ignored when empty)
//   full/empty    : occupancy flags
//   count         : occupancy, 0..DEPTH
//   front         : head entry (valid when !empty)
// -----------------------------------------------------------------------------
module w_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           front
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and next-pointer computation.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        full      = (count == (AW+1)'(DEPTH));
        empty     = (count == (AW+1)'(0));
        front     = mem_q[rd_ptr_q[AW-1:0]];
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    end

    // Pointer and storage registers; reset clears everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: rtl/w_scheduler.sv
// -----------------------------------------------------------------------------
// w_scheduler
// Arbitrates AW requests from NUM_MASTERS masters onto one slave AW port
// (round-robin, grant held until accepted) and steers W beats to the slave in
// the order the AW handshakes completed.
// Ports:
//   ACLK, ARESET                 : clock, asynchronous active-high reset
//   AWVALID_M / AWREADY_M        : per-master AW handshake
//   AWVALID_S / AWREADY_S, AWSEL : slave AW handshake and granted master index
//   WVALID_M, WLAST_M, WDATA_M, WSTRB_M / WREADY_M : per-master W channel
//   WVALID_S, WDATA_S, WSTRB_S, WLAST_S / WREADY_S : steered slave W channel
//   OUTSTANDING                  : order-queue occupancy
// AWVALID_S/AWSEL are combinational in the grant cycle so a free slave can
// accept the winner without an extra cycle.
// -----------------------------------------------------------------------------
module w_scheduler
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ORDER_DEPTH = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = 4,
    parameter int SEL_WIDTH   = mid_width_f(NUM_MASTERS)
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [NUM_MASTERS-1:0]            AWVALID_M,
    output logic [NUM_MASTERS-1:0]            AWREADY_M,
    output logic                              AWVALID_S,
    input  logic                              AWREADY_S,
    output logic [SEL_WIDTH-1:0]              AWSEL,
    input  logic [NUM_MASTERS-1:0]            WVALID_M,
    input  logic [NUM_MASTERS-1:0]            WLAST_M,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] WDATA_M,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] WSTRB_M,
    output logic [NUM_MASTERS-1:0]            WREADY_M,
    output logic                              WVALID_S,
    output logic [DATA_WIDTH-1:0]             WDATA_S,
    output logic [STRB_WIDTH-1:0]             WSTRB_S,
    output logic                              WLAST_S,
    input  logic                              WREADY_S,
    output logic [$clog2(ORDER_DEPTH):0]      OUTSTANDING
);

    localparam int CNT_WIDTH = $clog2(ORDER_DEPTH) + 1;
    // Wide enough for start (<= N) plus offset (<= N-1) without overflow.
    localparam int RR_WIDTH  = SEL_WIDTH + 2;

    aw_state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]       hold_sel_q, hold_sel_d;
    logic [SEL_WIDTH-1:0]       last_grant_q, last_grant_d;

    logic [2*NUM_MASTERS-1:0]   rr_req_dbl_s;
    logic [NUM_MASTERS-1:0]     rr_req_rot_s;
    logic [RR_WIDTH-1:0]        rr_start_s;
    logic [RR_WIDTH-1:0]        rr_offset_s;
    logic [RR_WIDTH-1:0]        rr_sum_s;
    logic [RR_WIDTH-1:0]        rr_wrap_s;
    logic                       rr_found_s;
    logic [SEL_WIDTH-1:0]       rr_winner_s;

    logic                       aw_valid_s;
    logic [SEL_WIDTH-1:0]       aw_sel_s;
    logic                       aw_hs_s;
    logic [NUM_MASTERS-1:0]     aw_ready_m_s;

    logic                       q_push_s;
    logic                       q_pop_s;
    logic                       q_full_s;
    logic                       q_empty_s;
    logic [CNT_WIDTH-1:0]       q_count_s;
    logic [SEL_WIDTH-1:0]       q_head_s;

    logic                       w_valid_s;
    logic [DATA_WIDTH-1:0]      w_data_s;
    logic [STRB_WIDTH-1:0]      w_strb_s;
    logic                       w_last_s;
    logic [NUM_MASTERS-1:0]     w_ready_m_s;

    // Round-robin pick: rotate the request vector so the search starts at
    // last_grant+1, take the lowest set bit, then rotate the offset back.
    always_comb begin
        rr_start_s   = RR_WIDTH'(last_grant_q) + RR_WIDTH'(1);
        rr_req_dbl_s = {AWVALID_M, AWVALID_M};
        rr_req_rot_s = NUM_MASTERS'(rr_req_dbl_s >> rr_start_s);
        rr_found_s   = 1'b0;
        rr_offset_s  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            rr_found_s  = rr_found_s | rr_req_rot_s[i];
            rr_offset_s = rr_req_rot_s[i] ? RR_WIDTH'(i) : rr_offset_s;
        end
        rr_sum_s    = rr_start_s + rr_offset_s;
        rr_wrap_s   = (rr_sum_s >= RR_WIDTH'(NUM_MASTERS)) ?
                      (rr_sum_s - RR_WIDTH'(NUM_MASTERS)) : rr_sum_s;
        rr_winner_s = SEL_WIDTH'(rr_wrap_s);
    end

    // AW FSM next state: grant in IDLE, freeze the selection in HOLD.
    always_comb begin
        state_d    = state_q;
        hold_sel_d = hold_sel_q;
        aw_valid_s = 1'b0;
        aw_sel_s   = '0;
        case (state_q)
            AW_IDLE: begin
                if (rr_found_s && !q_full_s) begin
                    aw_valid_s = 1'b1;
                    aw_sel_s   = rr_winner_s;
                    hold_sel_d = rr_winner_s;
                    state_d    = AWREADY_S ? AW_IDLE : AW_HOLD;
                end else begin
                    state_d    = AW_IDLE;
                end
            end
            AW_HOLD: begin
                aw_valid_s = 1'b1;
                aw_sel_s   = hold_sel_q;
                state_d    = AWREADY_S ? AW_IDLE : AW_HOLD;
            end
            default: begin
                state_d    = AW_IDLE;
            end
        endcase
        aw_hs_s      = aw_valid_s & AWREADY_S;
        q_push_s     = aw_hs_s;
        last_grant_d = aw_hs_s ? aw_sel_s : last_grant_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            aw_ready_m_s[i] = aw_hs_s & (aw_sel_s == SEL_WIDTH'(i));
        end
    end

    // AW FSM and arbitration history; master 0 has first priority after reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= AW_IDLE;
            hold_sel_q   <= '0;
            last_grant_q <= SEL_WIDTH'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            hold_sel_q   <= hold_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    w_order_fifo #(
        .WIDTH (SEL_WIDTH),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (q_push_s),
        .push_data (aw_sel_s),
        .pop       (q_pop_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s),
        .front     (q_head_s)
    );

    // W steering from the queue head. A push only becomes visible at the head
    // after the clock edge, so a beat can never bypass its own AW handshake.
    always_comb begin
        w_valid_s   = 1'b0;
        w_data_s    = '0;
        w_strb_s    = '0;
        w_last_s    = 1'b0;
        w_ready_m_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!q_empty_s && (q_head_s == SEL_WIDTH'(i))) begin
                w_valid_s      = WVALID_M[i];
                w_data_s       = WDATA_M[i*DATA_WIDTH +: DATA_WIDTH];
                w_strb_s       = WSTRB_M[i*STRB_WIDTH +: STRB_WIDTH];
                w_last_s       = WLAST_M[i];
                w_ready_m_s[i] = WREADY_S;
            end else begin
                w_ready_m_s[i] = 1'b0;
            end
        end
        q_pop_s = w_valid_s & WREADY_S & w_last_s;
    end

    // Output drive; reset forces every output low without waiting for a clock.
    always_comb begin
        if (ARESET) begin
            AWVALID_S   = 1'b0;
            AWSEL       = '0;
            AWREADY_M   = '0;
            WVALID_S    = 1'b0;
            WDATA_S     = '0;
            WSTRB_S     = '0;
            WLAST_S     = 1'b0;
            WREADY_M    = '0;
            OUTSTANDING = '0;
        end else begin
            AWVALID_S   = aw_valid_s;
            AWSEL       = aw_sel_s;
            AWREADY_M   = aw_ready_m_s;
            WVALID_S    = w_valid_s;
            WDATA_S     = w_data_s;
            WSTRB_S     = w_strb_s;
            WLAST_S     = w_last_s;
            WREADY_M    = w_ready_m_s;
            OUTSTANDING = q_count_s;
        end
    end

endmodule

// File: tb/tb_w_scheduler.sv
// -----------------------------------------------------------------------------
// tb_w_scheduler
// Directed table of per-cycle vectors plus hand-written sequences for grant
// hold, W ordering, queue-full blocking and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_w_scheduler;

    localparam int NM = 4;
    localparam int OD = 4;
    localparam int DW = 32;
    localparam int SW = 4;

    localparam logic [NM*DW-1:0] DDEF = {32'hD3D3_3333, 32'hD2D2_2222,
                                         32'hD1D1_1111, 32'hD0D0_0000};

    logic              aclk;
    logic              areset;
    logic [NM-1:0]     awvalid_m;
    logic [NM-1:0]     awready_m;
    logic              awvalid_s;
    logic              awready_s;
    logic [1:0]        awsel;
    logic [NM-1:0]     wvalid_m;
    logic [NM-1:0]     wlast_m;
    logic [NM*DW-1:0]  wdata_m;
    logic [NM*SW-1:0]  wstrb_m;
    logic [NM-1:0]     wready_m;
    logic              wvalid_s;
    logic [DW-1:0]     wdata_s;
    logic [SW-1:0]     wstrb_s;
    logic              wlast_s;
    logic              wready_s;
    logic [2:0]        outstanding;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] awv;
        logic       awr;
        logic [3:0] wv;
        logic [3:0] wl;
        logic       wr;
        logic       e_awv;
        logic [1:0] e_sel;
        logic [3:0] e_awr_m;
        int         src;      // master whose W beat is expected, 4 = queue empty
        logic [3:0] e_wr_m;
        logic [2:0] e_outs;
    } vec_t;

    vec_t tbl [14];

    w_scheduler #(
        .NUM_MASTERS (NM),
        .ORDER_DEPTH (OD),
        .DATA_WIDTH  (DW),
        .STRB_WIDTH  (SW)
    ) u_dut (
        .ACLK        (aclk),
        .ARESET      (areset),
        .AWVALID_M   (awvalid_m),
        .AWREADY_M   (awready_m),
        .AWVALID_S   (awvalid_s),
        .AWREADY_S   (awready_s),
        .AWSEL       (awsel),
        .WVALID_M    (wvalid_m),
        .WLAST_M     (wlast_m),
        .WDATA_M     (wdata_m),
        .WSTRB_M     (wstrb_m),
        .WREADY_M    (wready_m),
        .WVALID_S    (wvalid_s),
        .WDATA_S     (wdata_s),
        .WSTRB_S     (wstrb_s),
        .WLAST_S     (wlast_s),
        .WREADY_S    (wready_s),
        .OUTSTANDING (outstanding)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                         input logic [3:0] wl, input logic wr, input logic [NM*DW-1:0] wd);
        @(negedge aclk);
        awvalid_m = awv;
        awready_s = awr;
        wvalid_m  = wv;
        wlast_m   = wl;
        wready_s  = wr;
        wdata_m   = wd;
        #1;
    endtask

    task automatic chk_aw(input string tag, input logic e_awv, input logic [1:0] e_sel,
                          input logic [3:0] e_awr_m);
        chk({tag, " awvalid_s"}, 32'(awvalid_s), 32'(e_awv));
        if (e_awv) begin
            chk({tag, " awsel"}, 32'(awsel), 32'(e_sel));
        end
        chk({tag, " awready_m"}, 32'(awready_m), 32'(e_awr_m));
    endtask

    task automatic chk_w(input string tag, input int src, input logic [3:0] e_wr_m);
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_strb;
        logic          e_v;
        logic          e_l;
        if (src < NM) begin
            e_data = wdata_m[src*DW +: DW];
            e_strb = wstrb_m[src*SW +: SW];
            e_v    = wvalid_m[src];
            e_l    = wlast_m[src];
        end else begin
            e_data = '0;
            e_strb = '0;
            e_v    = 1'b0;
            e_l    = 1'b0;
        end
        chk({tag, " wvalid_s"}, 32'(wvalid_s), 32'(e_v));
        chk({tag, " wdata_s"},  32'(wdata_s),  32'(e_data));
        chk({tag, " wstrb_s"},  32'(wstrb_s),  32'(e_strb));
        chk({tag, " wlast_s"},  32'(wlast_s),  32'(e_l));
        chk({tag, " wready_m"}, 32'(wready_m), 32'(e_wr_m));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " awvalid_s"},   32'(awvalid_s),   32'd0);
        chk({tag, " awsel"},       32'(awsel),       32'd0);
        chk({tag, " awready_m"},   32'(awready_m),   32'd0);
        chk({tag, " wvalid_s"},    32'(wvalid_s),    32'd0);
        chk({tag, " wdata_s"},     32'(wdata_s),     32'd0);
        chk({tag, " wstrb_s"},     32'(wstrb_s),     32'd0);
        chk({tag, " wlast_s"},     32'(wlast_s),     32'd0);
        chk({tag, " wready_m"},    32'(wready_m),    32'd0);
        chk({tag, " outstanding"}, 32'(outstanding), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge aclk);
        areset    = 1'b1;
        awvalid_m = 4'b1111;
        awready_s = 1'b1;
        wvalid_m  = 4'b1111;
        wlast_m   = 4'b1111;
        wready_s  = 1'b1;
        #1;
        chk_zero(tag);
        @(negedge aclk);
        areset    = 1'b0;
        awvalid_m = 4'b0000;
        awready_s = 1'b0;
        wvalid_m  = 4'b0000;
        wlast_m   = 4'b0000;
        wready_s  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        areset    = 1'b1;
        awvalid_m = '0;
        awready_s = 1'b0;
        wvalid_m  = '0;
        wlast_m   = '0;
        wready_s  = 1'b0;
        wdata_m   = DDEF;
        wstrb_m   = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

        //            awv      awr   wv       wl       wr    e_awv e_sel e_awr_m  src e_wr_m   outs
        tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 4, 4'b0000, 3'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 0, 4'b0001, 3'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 0, 4'b0001, 3'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 0, 4'b0001, 3'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 0, 4'b0001, 3'd4};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd0, 4'b0001, 1, 4'b0010, 3'd3};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 2, 4'b0100, 3'd3};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 2, 4'b0100, 3'd3};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 2, 4'b0100, 3'd3};
        tbl[9]  = '{4'b0010, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd1, 4'b0010, 3, 4'b1000, 3'd2};
        tbl[10] = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 0, 4'b0000, 3'd2};
        tbl[11] = '{4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 0, 4'b0001, 3'd2};
        tbl[12] = '{4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1, 4'b0010, 3'd1};
        tbl[13] = '{4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 4, 4'b0000, 3'd0};

        // Table: round-robin fill, full blocking, simultaneous push/pop, steering.
        do_reset("rst0");
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].awv, tbl[i].awr, tbl[i].wv, tbl[i].wl, tbl[i].wr, DDEF);
            chk_aw($sformatf("vec%0d", i), tbl[i].e_awv, tbl[i].e_sel, tbl[i].e_awr_m);
            chk_w($sformatf("vec%0d", i), tbl[i].src, tbl[i].e_wr_m);
            chk($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'(tbl[i].e_outs));
        end

        // Hold: master 2 granted, slave stalls 3 cycles while master 1 requests.
        do_reset("rst1");
        drive(4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, DDEF);
        chk_aw("hold0", 1'b1, 2'd2, 4'b0000);
        for (int i = 1; i < 3; i++) begin
            drive(4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0, DDEF);
            chk_aw($sformatf("hold%0d", i), 1'b1, 2'd2, 4'b0000);
        end
        drive(4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0, DDEF);
        chk_aw("hold_acc", 1'b1, 2'd2, 4'b0100);
        drive(4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, DDEF);
        chk_aw("hold_next", 1'b1, 2'd1, 4'b0010);
        chk("hold_next outstanding", 32'(outstanding), 32'd1);

        // Ordering: AW 3 then 0, two-beat bursts, both masters keep WVALID high.
        do_reset("rst2");
        drive(4'b1000, 1'b1, 4'b1001, 4'b0000, 1'b1,
              {32'h3B3B_0000, 32'h0, 32'h0, 32'h0A0A_0000});
        chk_aw("ord0", 1'b1, 2'd3, 4'b1000);
        chk_w("ord0_nobypass", 4, 4'b0000);
        drive(4'b0001, 1'b1, 4'b1001, 4'b0000, 1'b1,
              {32'h3B3B_0000, 32'h0, 32'h0, 32'h0A0A_0000});
        chk_aw("ord1", 1'b1, 2'd0, 4'b0001);
        chk_w("ord1", 3, 4'b1000);
        drive(4'b0000, 1'b0, 4'b1001, 4'b1000, 1'b1,
              {32'h3B3B_0001, 32'h0, 32'h0, 32'h0A0A_0000});
        chk_w("ord2", 3, 4'b1000);
        chk("ord2 outstanding", 32'(outstanding), 32'd2);
        drive(4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1,
              {32'h0, 32'h0, 32'h0, 32'h0A0A_0000});
        chk_w("ord3", 0, 4'b0001);
        chk("ord3 outstanding", 32'(outstanding), 32'd1);
        drive(4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1,
              {32'h0, 32'h0, 32'h0, 32'h0A0A_0001});
        chk_w("ord4", 0, 4'b0001);
        drive(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, DDEF);
        chk_w("ord5", 4, 4'b0000);
        chk("ord5 outstanding", 32'(outstanding), 32'd0);

        // Full: four grants, requests blocked, one pop frees a slot next cycle.
        do_reset("rst3");
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, DDEF);
            chk_aw($sformatf("fill%0d", i), 1'b1, 2'(i), 4'(1 << i));
        end
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, DDEF);
            chk_aw($sformatf("full%0d", i), 1'b0, 2'd0, 4'b0000);
            chk($sformatf("full%0d outstanding", i), 32'(outstanding), 32'd4);
        end
        drive(4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, DDEF);
        chk_aw("full_pop", 1'b0, 2'd0, 4'b0000);
        chk_w("full_pop", 0, 4'b0001);
        drive(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, DDEF);
        chk_aw("full_regrant", 1'b1, 2'd0, 4'b0001);
        chk("full_regrant outstanding", 32'(outstanding), 32'd3);

        // Asynchronous reset mid-cycle with a full queue and a head beat pending.
        drive(4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1, DDEF);
        chk_w("pre_rst", 1, 4'b0010);
        chk("pre_rst outstanding", 32'(outstanding), 32'd4);
        #2;
        areset = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge aclk);
        areset    = 1'b0;
        awready_s = 1'b0;
        wvalid_m  = 4'b1111;
        wlast_m   = 4'b1111;
        #1;
        chk_aw("post_rst", 1'b1, 2'd0, 4'b0000);
        chk_w("post_rst", 4, 4'b0000);
        drive(4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b1, DDEF);
        chk_w("post_rst_hold", 4, 4'b0000);
        chk("post_rst_hold outstanding", 32'(outstanding), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
